aes_engine_scheduler: RTL and testbench

Two-requester scheduler that shares one `aes_engine` instance. Accepts 128-bit key/plaintext jobs from two clients and picks one by round-robin. Drives the engine's byte-serial `din`/`cmd` load interface, waits for `engine_done`, and returns the captured ciphertext to the granted client. Sits directly above `aes_engine`; clients never touch the engine ports.

---
 rtl/aes_engine_scheduler_if.sv | 36 +++
 rtl/aes_engine_scheduler.sv | 195 +++++++++++++++++++
 tb/tb_aes_engine_scheduler.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/aes_engine_scheduler_if.sv
// Client and engine-side signal bundle for aes_engine_scheduler.
// slave = scheduler view, master = environment (clients + engine) view.
interface aes_engine_scheduler_if;
   logic         req0_valid;
   logic         req1_valid;
   logic [127:0] req0_key;
   logic [127:0] req1_key;
   logic [127:0] req0_pt;
   logic [127:0] req1_pt;
   logic         req0_ready;
   logic         req1_ready;
   logic         resp0_valid;
   logic         resp1_valid;
   logic [127:0] resp_ct;
   logic         resp_err;
   logic [7:0]   eng_din;
   logic [1:0]   eng_cmd;
   logic         eng_ready;
   logic         eng_done;
   logic [127:0] eng_ct;
   logic         busy;

   modport slave (
      input  req0_valid, req1_valid, req0_key, req1_key, req0_pt, req1_pt,
      input  eng_ready, eng_done, eng_ct,
      output req0_ready, req1_ready, resp0_valid, resp1_valid, resp_ct, resp_err,
      output eng_din, eng_cmd, busy
   );

   modport master (
      output req0_valid, req1_valid, req0_key, req1_key, req0_pt, req1_pt,
      output eng_ready, eng_done, eng_ct,
      input  req0_ready, req1_ready, resp0_valid, resp1_valid, resp_ct, resp_err,
      input  eng_din, eng_cmd, busy
   );
endinterface

// File: rtl/aes_engine_scheduler.sv
// Round-robin two-client scheduler feeding one byte-serial aes_engine.
// Optional WAIT timeout enabled by defining AES_SCHED_TIMEOUT_EN.
module aes_engine_scheduler #(
`ifdef AES_SCHED_TIMEOUT_EN
   parameter int unsigned TIMEOUT   = 64,
`endif
   parameter logic [1:0]  CMD_IDLE  = 2'b00,
   parameter logic [1:0]  CMD_KEY   = 2'b01,
   parameter logic [1:0]  CMD_PLAIN = 2'b10,
   parameter logic [1:0]  CMD_START = 2'b11
) (
   input  logic                    clk,
   input  logic                    rst,
   aes_engine_scheduler_if.slave   bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_KEY,
      S_LOAD_PT,
      S_START,
      S_WAIT,
      S_RESP
   } state_e;

   state_e       state_q;
   logic [127:0] key_q;
   logic [127:0] pt_q;
   logic [127:0] ct_q;
   logic [3:0]   cnt_q;
   logic         gnt_q;
   logic         last_q;
   logic         err_q;
   logic         busy_q;
   logic         rdy0_q;
   logic         rdy1_q;
   logic         rv0_q;
   logic         rv1_q;
   logic [7:0]   din_q;
   logic [1:0]   cmd_q;
`ifdef AES_SCHED_TIMEOUT_EN
   logic [15:0]  tcnt_q;
`endif

   logic         req_any_s;
   logic         gnt_d;

   // Byte idx 0 is the most significant byte [127:120].
   function automatic logic [7:0] sel_byte(input logic [127:0] d, input logic [3:0] idx);
      logic [6:0] sh;
      sh = {4'd15 - idx, 3'b000};
      return 8'(d >> sh);
   endfunction

   always_comb begin
      req_any_s = bus.req0_valid | bus.req1_valid;
      if (bus.req0_valid && bus.req1_valid) begin
         gnt_d = ~last_q;
      end else if (bus.req1_valid) begin
         gnt_d = 1'b1;
      end else begin
         gnt_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         key_q   <= 128'd0;
         pt_q    <= 128'd0;
         ct_q    <= 128'd0;
         cnt_q   <= 4'd0;
         gnt_q   <= 1'b0;
         last_q  <= 1'b1;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         rdy0_q  <= 1'b0;
         rdy1_q  <= 1'b0;
         rv0_q   <= 1'b0;
         rv1_q   <= 1'b0;
         din_q   <= 8'd0;
         cmd_q   <= CMD_IDLE;
`ifdef AES_SCHED_TIMEOUT_EN
         tcnt_q  <= 16'd0;
`endif
      end else begin
         rdy0_q <= 1'b0;
         rdy1_q <= 1'b0;
         rv0_q  <= 1'b0;
         rv1_q  <= 1'b0;
         case (state_q)
            S_IDLE: begin
               cmd_q <= CMD_IDLE;
               din_q <= 8'd0;
               if (req_any_s) begin
                  gnt_q   <= gnt_d;
                  last_q  <= gnt_d;
                  rdy0_q  <= ~gnt_d;
                  rdy1_q  <= gnt_d;
                  key_q   <= gnt_d ? bus.req1_key : bus.req0_key;
                  pt_q    <= gnt_d ? bus.req1_pt  : bus.req0_pt;
                  cnt_q   <= 4'd0;
                  busy_q  <= 1'b1;
                  state_q <= S_LOAD_KEY;
               end else begin
                  busy_q  <= 1'b0;
               end
            end
            S_LOAD_KEY: begin
               if (bus.eng_ready) begin
                  cmd_q <= CMD_KEY;
                  din_q <= sel_byte(key_q, cnt_q);
                  cnt_q <= cnt_q + 4'd1;
                  if (cnt_q == 4'd15) begin
                     state_q <= S_LOAD_PT;
                  end
               end else begin
                  cmd_q <= CMD_IDLE;
                  din_q <= 8'd0;
               end
            end
            S_LOAD_PT: begin
               if (bus.eng_ready) begin
                  cmd_q <= CMD_PLAIN;
                  din_q <= sel_byte(pt_q, cnt_q);
                  cnt_q <= cnt_q + 4'd1;
                  if (cnt_q == 4'd15) begin
                     state_q <= S_START;
                  end
               end else begin
                  cmd_q <= CMD_IDLE;
                  din_q <= 8'd0;
               end
            end
            S_START: begin
               din_q <= 8'd0;
               if (bus.eng_ready) begin
                  cmd_q   <= CMD_START;
                  state_q <= S_WAIT;
`ifdef AES_SCHED_TIMEOUT_EN
                  tcnt_q  <= 16'd0;
`endif
               end else begin
                  cmd_q   <= CMD_IDLE;
               end
            end
            S_WAIT: begin
               cmd_q <= CMD_IDLE;
               din_q <= 8'd0;
               // The response pulse is raised on RESP entry so it coincides with RESP.
               if (bus.eng_done) begin
                  ct_q    <= bus.eng_ct;
                  err_q   <= 1'b0;
                  rv0_q   <= ~gnt_q;
                  rv1_q   <= gnt_q;
                  state_q <= S_RESP;
`ifdef AES_SCHED_TIMEOUT_EN
               end else if (tcnt_q == 16'(TIMEOUT - 1)) begin
                  ct_q    <= 128'd0;
                  err_q   <= 1'b1;
                  rv0_q   <= ~gnt_q;
                  rv1_q   <= gnt_q;
                  state_q <= S_RESP;
               end else begin
                  tcnt_q  <= tcnt_q + 16'd1;
`endif
               end
            end
            S_RESP: begin
               cmd_q   <= CMD_IDLE;
               din_q   <= 8'd0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               cmd_q   <= CMD_IDLE;
               din_q   <= 8'd0;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.req0_ready  = rdy0_q;
   assign bus.req1_ready  = rdy1_q;
   assign bus.resp0_valid = rv0_q;
   assign bus.resp1_valid = rv1_q;
   assign bus.resp_ct     = ct_q;
   assign bus.resp_err    = err_q;
   assign bus.eng_din     = din_q;
   assign bus.eng_cmd     = cmd_q;
   assign bus.busy        = busy_q;

endmodule

// File: tb/tb_aes_engine_scheduler.sv
// Directed self-checking bench for aes_engine_scheduler with a byte-capturing engine model.
module tb_aes_engine_scheduler;
   localparam logic [1:0]   C_IDLE  = 2'b00;
   localparam logic [1:0]   C_KEY   = 2'b01;
   localparam logic [1:0]   C_PLAIN = 2'b10;
   localparam logic [1:0]   C_START = 2'b11;
   localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] FIPS_PT  = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] FIPS_CT  = 128'h3925841d02dc09fbdc118597196a0b32;

   typedef struct {
      logic [127:0] key;
      logic [127:0] pt;
   } job_t;

   typedef struct {
      int           client;
      logic [127:0] ct;
      logic         err;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   aes_engine_scheduler_if bus();

   aes_engine_scheduler dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Engine model state
   logic [127:0] key_sh = 128'd0;
   logic [127:0] pt_sh  = 128'd0;
   logic [127:0] ct_v   = 128'd0;
   logic         done_v = 1'b0;
   logic         spur_done = 1'b0;
   logic         eng_rdy = 1'b1;
   bit           eng_active = 1'b0;
   int n_key = 0, n_pt = 0, n_start = 0, n_idle_key = 0, din_bad = 0;
   int done_left = 0, start_cyc = 0, done_cyc = 0;
   int done_delay = 3;

   assign bus.eng_done  = done_v | spur_done;
   assign bus.eng_ct    = ct_v;
   assign bus.eng_ready = eng_rdy;

   // Clients / scoreboard state
   job_t jq0[$];
   job_t jq1[$];
   exp_t eq[$];
   int   grants[$];
   int   ready_cyc = 0, resp_cyc = 0, last_resp_cyc = -100, n_resp = 0;
   bit   chk_gap = 1'b0;
   bit   exp_timeout = 1'b0;

   function automatic logic [127:0] model_ct(input logic [127:0] k, input logic [127:0] p);
      if (k == FIPS_KEY && p == FIPS_PT) return FIPS_CT;
      return k ^ {p[63:0], p[127:64]};
   endfunction

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Engine model: captures loaded bytes, answers START after done_delay cycles.
   always @(negedge clk) begin
      done_v <= 1'b0;
      if (eng_active) begin
         if (done_left == 0) begin
            done_v     <= 1'b1;
            ct_v       <= model_ct(key_sh, pt_sh);
            eng_active <= 1'b0;
            done_cyc   <= cyc;
         end else begin
            done_left <= done_left - 1;
         end
      end
      case (bus.eng_cmd)
         C_KEY: begin
            key_sh <= {key_sh[119:0], bus.eng_din};
            n_key  <= n_key + 1;
         end
         C_PLAIN: begin
            pt_sh <= {pt_sh[119:0], bus.eng_din};
            n_pt  <= n_pt + 1;
         end
         C_START: begin
            n_start   <= n_start + 1;
            start_cyc <= cyc;
            if (done_delay >= 0) begin
               eng_active <= 1'b1;
               done_left  <= done_delay;
            end
         end
         default: begin
            if (bus.eng_din != 8'd0) din_bad <= din_bad + 1;
            if ((n_key % 16) != 0) n_idle_key <= n_idle_key + 1;
         end
      endcase
   end

   task automatic accept(input int c, input job_t j);
      exp_t e;
      grants.push_back(c);
      if (chk_gap) chk("idle_gap", cyc - last_resp_cyc, 2);
      ready_cyc = cyc;
      e.client = c;
      e.ct     = exp_timeout ? 128'd0 : model_ct(j.key, j.pt);
      e.err    = exp_timeout;
      eq.push_back(e);
   endtask

   task automatic clients_tick();
      exp_t e;
      if (bus.resp0_valid === 1'b1 || bus.resp1_valid === 1'b1) begin
         n_resp++;
         resp_cyc      = cyc;
         last_resp_cyc = cyc;
         chk("resp_onehot", bus.resp0_valid & bus.resp1_valid, 0);
         chk("resp_expected", eq.size() != 0, 1);
         if (eq.size() != 0) begin
            e = eq.pop_front();
            chk("resp_client", bus.resp1_valid, e.client);
            chk("resp_ct", bus.resp_ct, e.ct);
            chk("resp_err", bus.resp_err, e.err);
            if (!e.err) chk("resp_latency", cyc - done_cyc, 1);
         end
      end
      if (bus.req0_valid === 1'b1 && bus.req0_ready === 1'b1) begin
         accept(0, jq0.pop_front());
         bus.req0_valid = 1'b0;
      end
      if (bus.req1_valid === 1'b1 && bus.req1_ready === 1'b1) begin
         accept(1, jq1.pop_front());
         bus.req1_valid = 1'b0;
      end
      if (bus.req0_valid !== 1'b1 && jq0.size() > 0) begin
         bus.req0_valid = 1'b1;
         bus.req0_key   = jq0[0].key;
         bus.req0_pt    = jq0[0].pt;
      end
      if (bus.req1_valid !== 1'b1 && jq1.size() > 0) begin
         bus.req1_valid = 1'b1;
         bus.req1_key   = jq1[0].key;
         bus.req1_pt    = jq1[0].pt;
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      clients_tick();
   endtask

   function automatic bit all_idle();
      return jq0.size() == 0 && jq1.size() == 0 && eq.size() == 0 &&
             bus.busy === 1'b0 && bus.req0_valid === 1'b0 && bus.req1_valid === 1'b0;
   endfunction

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (all_idle()) break;
         step();
      end
      chk("drain", all_idle(), 1);
   endtask

   task automatic wait_for(input logic [1:0] c, input logic [7:0] d, input int budget, input string tag);
      bit found;
      found = 1'b0;
      for (int i = 0; i < budget; i++) begin
         if (bus.eng_cmd === c && bus.eng_din === d) begin
            found = 1'b1;
            break;
         end
         step();
      end
      chk(tag, found, 1);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_ready0"}, bus.req0_ready, 0);
      chk({tag, "_ready1"}, bus.req1_ready, 0);
      chk({tag, "_resp0"},  bus.resp0_valid, 0);
      chk({tag, "_resp1"},  bus.resp1_valid, 0);
      chk({tag, "_ct"},     bus.resp_ct, 0);
      chk({tag, "_err"},    bus.resp_err, 0);
      chk({tag, "_din"},    bus.eng_din, 0);
      chk({tag, "_cmd"},    bus.eng_cmd, C_IDLE);
      chk({tag, "_busy"},   bus.busy, 0);
   endtask

   task automatic drop_clients();
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      jq0.delete();
      jq1.delete();
      eq.delete();
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      drop_clients();
      step();
      check_reset(tag);
      rst = 1'b0;
      grants.delete();
   endtask

   initial begin
      int base_k, base_p, base_s, base_r, base_i;
      job_t j;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.req0_key   = 128'd0;
      bus.req1_key   = 128'd0;
      bus.req0_pt    = 128'd0;
      bus.req1_pt    = 128'd0;
      rst = 1'b1;
      repeat (2) step();
      check_reset("por");
      rst = 1'b0;

      // Single FIPS-197 job on client 0
      base_k = n_key; base_p = n_pt; base_s = n_start; base_r = n_resp;
      j.key = FIPS_KEY; j.pt = FIPS_PT;
      jq0.push_back(j);
      wait_drain(200);
      chk("t1_key_bytes", key_sh, FIPS_KEY);
      chk("t1_pt_bytes", pt_sh, FIPS_PT);
      chk("t1_key_loads", n_key - base_k, 16);
      chk("t1_pt_loads", n_pt - base_p, 16);
      chk("t1_starts", n_start - base_s, 1);
      chk("t1_start_latency", start_cyc - ready_cyc, 33);
      chk("t1_resp_count", n_resp - base_r, 1);
      chk("t1_ct_hold", bus.resp_ct, FIPS_CT);

      // Contention from reset: expect 0,1,0,1; last two jobs carry identical data
      do_reset("rst2");
      base_r = n_resp;
      j.key = 128'h0123456789abcdef0011223344556677; j.pt = 128'h1; jq0.push_back(j);
      j.key = 128'hfedcba98765432100123456789abcdef; j.pt = 128'h2; jq1.push_back(j);
      j.key = 128'h55555555aaaaaaaa55555555aaaaaaaa; j.pt = 128'h3; jq0.push_back(j);
      jq1.push_back(j);
      for (int i = 0; i < 200 && n_resp == base_r; i++) step();
      chk_gap = 1'b1;
      wait_drain(400);
      chk_gap = 1'b0;
      chk("t2_grant_count", grants.size(), 4);
      if (grants.size() == 4) begin
         chk("t2_grant0", grants[0], 0);
         chk("t2_grant1", grants[1], 1);
         chk("t2_grant2", grants[2], 0);
         chk("t2_grant3", grants[3], 1);
      end
      chk("t2_resp_count", n_resp - base_r, 4);

      // eng_ready stall for 5 cycles before key byte 7
      base_k = n_key; base_p = n_pt; base_i = n_idle_key;
      j.key = 128'h00112233445566778899aabbccddeeff; j.pt = 128'h0f1e2d3c4b5a69788796a5b4c3d2e1f0;
      jq0.push_back(j);
      wait_for(C_KEY, 8'h66, 100, "t3_reach_byte6");
      eng_rdy = 1'b0;
      repeat (5) step();
      eng_rdy = 1'b1;
      wait_drain(200);
      chk("t3_idle_cycles", n_idle_key - base_i, 5);
      chk("t3_key_loads", n_key - base_k, 16);
      chk("t3_pt_loads", n_pt - base_p, 16);
      chk("t3_key_bytes", key_sh, j.key);
      chk("t3_pt_bytes", pt_sh, j.pt);

      // Spurious eng_done while loading the key
      base_s = n_start; base_r = n_resp;
      j.key = 128'hdeadbeef0badf00dcafebabe12345678; j.pt = 128'h8badf00d;
      jq1.push_back(j);
      wait_for(C_KEY, 8'hde, 100, "t4_reach_key");
      spur_done = 1'b1;
      step();
      spur_done = 1'b0;
      wait_drain(200);
      chk("t4_starts", n_start - base_s, 1);
      chk("t4_resp_count", n_resp - base_r, 1);

      // Reset during LOAD_PT after byte 3, then two fresh jobs
      j.key = 128'h1; j.pt = 128'hf0f1f2f3f4f5f6f7f8f9fafbfcfdfeff;
      jq0.push_back(j);
      wait_for(C_PLAIN, 8'hf3, 100, "t5_reach_pt3");
      base_r = n_resp;
      do_reset("midrst");
      repeat (5) step();
      chk("t5_no_resp", n_resp - base_r, 0);
      j.key = 128'h77; j.pt = 128'h88; jq1.push_back(j);
      j.key = 128'h99; j.pt = 128'haa; jq0.push_back(j);
      wait_drain(300);
      chk("t5_resp_count", n_resp - base_r, 2);
      if (grants.size() > 0) chk("t5_first_grant", grants[0], 0);

      // Engine never answers
      done_delay = -1;
      base_s = n_start; base_r = n_resp;
      j.key = 128'habc; j.pt = 128'hdef;
`ifdef AES_SCHED_TIMEOUT_EN
      exp_timeout = 1'b1;
      jq0.push_back(j);
      wait_drain(300);
      exp_timeout = 1'b0;
      chk("t6_resp_count", n_resp - base_r, 1);
      chk("t6_timeout_latency", resp_cyc - start_cyc, 64);
      chk("t6_err_hold", bus.resp_err, 1);
`else
      jq0.push_back(j);
      repeat (200) step();
      chk("t6_busy_stuck", bus.busy, 1);
      chk("t6_no_resp", n_resp - base_r, 0);
      chk("t6_starts", n_start - base_s, 1);
      do_reset("rst6");
`endif
      done_delay = 3;

      chk("din_zero_when_idle", din_bad, 0);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule
